// File: rtl/bus_timer_pkg.sv
// Shared register map, interrupt FSM encoding and write-decode type for bus_timer.
// Constants only: no latency and no backpressure.
package bus_timer_pkg;

    localparam logic [7:0] TIMER_BASE_ADDR_DEFAULT = 8'hF0;

    localparam logic [1:0] OFF_VALUE   = 2'd0;
    localparam logic [1:0] OFF_PERIOD  = 2'd1;
    localparam logic [1:0] OFF_RESTART = 2'd2;
    localparam logic [1:0] OFF_IRQ_EN  = 2'd3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    typedef struct packed {
        logic period;
        logic restart;
        logic irq_en;
    } reg_wr_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..ClkPerTick-1 and pulses tick for one cycle on the wrap.
// Latency: tick is a decode of the count; clear lands on the next edge; no backpressure.
module tick_gen #(
    parameter int ClkPerTick = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    output logic tick
);

    localparam int CntW = (ClkPerTick > 1) ? $clog2(ClkPerTick) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ClkPerTick - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Bus-mapped periodic interrupt timer: free-running VALUE, PERIOD-based events, 2-state IRQ FSM.
// Latency: writes take effect on the strobe edge, reads drive BUS_DATA one cycle later; no backpressure.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [7:0] TimerBaseAddr = TIMER_BASE_ADDR_DEFAULT,
    parameter int         ClkPerTick    = 100000,
    parameter logic [7:0] InitialPeriod = 8'd100
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    inout  wire  [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    logic       addr_hit;
    logic [1:0] addr_off;
    logic       rd_hit;
    reg_wr_t    wr;
    logic       tick;
    logic       period_evt;

    logic [7:0] value_q,    value_d;
    logic [7:0] interval_q, interval_d;
    logic [7:0] period_q,   period_d;
    logic       irq_en_q,   irq_en_d;
    logic [0:0] state_q,    state_d;
    logic [7:0] rd_dat_q,   rd_dat_d;
    logic       drv_en_q,   drv_en_d;

    assign addr_hit = (BUS_ADDR[7:2] == TimerBaseAddr[7:2]);
    assign addr_off = BUS_ADDR[1:0];
    assign rd_hit   = addr_hit && !BUS_WE;

    always_comb begin
        wr         = '0;
        wr.period  = addr_hit && BUS_WE && (addr_off == OFF_PERIOD);
        wr.restart = addr_hit && BUS_WE && (addr_off == OFF_RESTART);
        wr.irq_en  = addr_hit && BUS_WE && (addr_off == OFF_IRQ_EN);
    end

    tick_gen #(
        .ClkPerTick(ClkPerTick)
    ) u_tick_gen (
        .CLK  (CLK),
        .RESET(RESET),
        .clear(wr.restart),
        .tick (tick)
    );

    // Restart and PERIOD writes win over a coincident tick, so the new timebase starts clean.
    always_comb begin
        value_d    = value_q;
        interval_d = interval_q;
        period_d   = period_q;
        irq_en_d   = irq_en_q;
        period_evt = 1'b0;

        if (wr.restart) begin
            value_d = '0;
        end else if (tick) begin
            value_d = value_q + 8'd1;
        end

        if (wr.period) begin
            period_d = BUS_DATA;
        end
        if (wr.irq_en) begin
            irq_en_d = BUS_DATA[0];
        end

        if (wr.restart || wr.period || (period_q == 8'd0)) begin
            interval_d = '0;
        end else if (tick) begin
            if (interval_q == (period_q - 8'd1)) begin
                interval_d = '0;
                period_evt = 1'b1;
            end else begin
                interval_d = interval_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (wr.irq_en && !BUS_DATA[0]) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (period_evt && irq_en_q) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    // A fresh event on the ack edge re-arms immediately instead of dropping.
                    if (BUS_INTERRUPT_ACK && !period_evt) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_dat_d = rd_dat_q;
        drv_en_d = rd_hit;
        if (rd_hit) begin
            case (addr_off)
                OFF_VALUE:  rd_dat_d = value_q;
                OFF_PERIOD: rd_dat_d = period_q;
                OFF_IRQ_EN: rd_dat_d = {7'd0, irq_en_q};
                default:    rd_dat_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            value_q    <= '0;
            interval_q <= '0;
            period_q   <= InitialPeriod;
            irq_en_q   <= 1'b1;
            state_q    <= ST_IDLE;
            rd_dat_q   <= '0;
            drv_en_q   <= 1'b0;
        end else begin
            value_q    <= value_d;
            interval_q <= interval_d;
            period_q   <= period_d;
            irq_en_q   <= irq_en_d;
            state_q    <= state_d;
            rd_dat_q   <= rd_dat_d;
            drv_en_q   <= drv_en_d;
        end
    end

    assign BUS_INTERRUPT_RAISE = (state_q == ST_PENDING);
    assign BUS_DATA            = drv_en_q ? rd_dat_q : 8'hzz;

endmodule
